pipe_pc_ifid: RTL and testbench
===============================

Name: pipe_pc_ifid

Overview:
- PC register plus IF/ID pipeline register for the 5-stage MIPS core.
- Drives the current pc into the fetch stage.
- Captures that stage's instruction and pc+8 result (instruction, npc, pc8) into ID-facing registers.
- Applies hazard-unit stall/flush.
- Provides a board-driven single-step mode and fetch/stall counters for the LED/segment debug display.

Parameters:
- RESET_PC, 32'h0000_0000, pc value loaded on reset (bits [1:0] must be 0).
- CNT_W, 16, width of fetch and stall counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- npc  in  32  next pc from fetch stage.
- if_inst  in  32  instruction read combinationally from iram at pc.
- if_pc8  in  32  pc+8 from fetch stage (jal link value).
- stall  in  1  hazard unit: hold pc and IF/ID.
- flush  in  1  squash instruction entering ID.
- step_mode  in  1  1 = single-step, 0 = free run (switch, already synchronised).
- step  in  1  step button level (already debounced and synchronised).
- pc  out  32  current pc to fetch stage.
- id_inst  out  32  instruction in ID.
- id_pc  out  32  pc of id_inst.
- id_pc8  out  32  pc+8 of id_inst.
- id_valid  out  1  id_inst is a real fetched instruction.
- fetch_cnt  out  CNT_W  instructions accepted into ID, wraps.
- stall_cnt  out  CNT_W  enabled cycles lost to stall, saturates at all-ones.
- step_state  out  2  FSM state for LED display.

Behaviour:
- Reset values (async, immediate): pc=RESET_PC, id_inst=0 (sll $0 NOP), id_pc=0, id_pc8=0, id_valid=0, fetch_cnt=0, stall_cnt=0, FSM=HOLD, step edge register=1.
  - The edge register resets to 1 so a button held through reset gives no spurious step.
- Step FSM, encoding RUN=2'b00, HOLD=2'b01, ADV=2'b10. step_rise = step & ~step_q, where step_q is step registered.
  - HOLD: step_mode=0 → RUN; step_mode=1 and step_rise → ADV; else stay.
  - ADV: lasts exactly one cycle; → HOLD if step_mode=1, else RUN.
  - RUN: step_mode=1 → HOLD; else stay.
- en = (state==RUN) | (state==ADV).
  - Pipeline advances at most one clock per step press.
  - Leaving reset costs one HOLD cycle even in free-run mode.
- Per-cycle update, priority top to bottom:
  - en=0: all pipeline registers and counters hold.
  - en & flush: pc<=npc; id_inst<=0, id_pc<=0, id_pc8<=0, id_valid<=0; counters hold. Flush overrides stall.
  - en & stall: pc and all id_* hold; stall_cnt<=stall_cnt+1 unless all-ones.
  - en, otherwise: pc<=npc; id_inst<=if_inst; id_pc<=pc; id_pc8<=if_pc8; id_valid<=1; fetch_cnt<=fetch_cnt+1 (wraps to 0).
- Alignment: pc[1:0] always 0; npc[1:0] ignored when loading.
- Latency: an instruction fetched at pc appears on id_inst one enabled edge later.
- Reset mid-step or mid-stall: everything returns to reset values at once. No pending step is remembered.
- step_mode change: a change in HOLD or RUN takes effect on the next edge. A change during ADV does not cancel that ADV cycle.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package (cpu_defs): NOP_INST=32'h0000_0000, step FSM state encodings, default RESET_PC.
- One natural sub-module: step_ctrl (edge detect + 3-state FSM, outputs en and step_state). The rest stays in pipe_pc_ifid.

Test Plan:
- Reset then free run: rst pulse, step_mode=0, npc=pc+4, if_inst=32'h2001_0005.
  - Cycle after reset stays HOLD.
  - Next edges: pc 0→4→8; id_inst=32'h2001_0005, id_pc=0, id_valid=1, fetch_cnt=1 after first advance.
- Stall: stall=1 for 3 enabled cycles at pc=8 → pc, id_* unchanged; stall_cnt=3; fetch_cnt unchanged. Release → pc=12.
- Flush with stall: flush=1, stall=1, npc=32'h0000_0040 → pc=0x40, id_inst=0, id_valid=0, stall_cnt unchanged.
- Single step: step_mode=1, hold step high for 10 cycles → exactly one advance, step_state sequence 01→10→01. Second press → second advance.
- Counter limits:
  - Force 65535 stall cycles, then one more → stall_cnt stays 16'hFFFF.
  - fetch_cnt at 16'hFFFF plus one accept → 0.
- Async reset mid-ADV: assert rst between edges → outputs reset immediately. After release, the button held high causes no step.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS core front end: NOP encoding, step FSM states
// and the default reset pc.
package cpu_defs;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HOLD = 2'b01,
    ST_ADV  = 2'b10
  } step_state_e;

endpackage

// File: rtl/pipe_pc_ifid_step_ctrl.sv
// Single-step controller: button edge detect plus RUN/HOLD/ADV FSM producing the
// pipeline enable.
module step_ctrl
  import cpu_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_mode,
  input  logic       step,
  output logic       en,
  output logic [1:0] step_state
);

  step_state_e state_q, state_d;
  logic        step_q, step_d;
  logic        step_rise;

  assign step_d    = step;
  assign step_rise = step & ~step_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: begin
        if (!step_mode)     state_d = ST_RUN;
        else if (step_rise) state_d = ST_ADV;
      end
      ST_ADV:  state_d = step_mode ? ST_HOLD : ST_RUN;
      ST_RUN:  if (step_mode) state_d = ST_HOLD;
      default: state_d = ST_HOLD;
    endcase
  end

  // step_q resets high so a button held through reset is not seen as a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HOLD;
      step_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  assign en         = (state_q == ST_RUN) || (state_q == ST_ADV);
  assign step_state = state_q;

endmodule

// File: rtl/pipe_pc_ifid.sv
// PC register and IF/ID pipeline register with hazard stall/flush, single-step
// gating and fetch/stall debug counters.
module pipe_pc_ifid
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      npc,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc8,
  input  logic             stall,
  input  logic             flush,
  input  logic             step_mode,
  input  logic             step,
  output logic [31:0]      pc,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc8,
  output logic             id_valid,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       step_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             en;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_pc8_q, id_pc8_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [31:0]      npc_aligned;
  logic             unused_npc_lo;

  step_ctrl u_step_ctrl (
    .clk        (clk),
    .rst        (rst),
    .step_mode  (step_mode),
    .step       (step),
    .en         (en),
    .step_state (step_state)
  );

  assign npc_aligned   = {npc[31:2], 2'b00};
  assign unused_npc_lo = ^npc[1:0];

  // flush outranks stall: a squashed slot must not keep the pc frozen
  always_comb begin
    pc_d        = pc_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_pc8_d    = id_pc8_q;
    id_valid_d  = id_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (en) begin
      if (flush) begin
        pc_d       = npc_aligned;
        id_inst_d  = NOP_INST;
        id_pc_d    = 32'h0;
        id_pc8_d   = 32'h0;
        id_valid_d = 1'b0;
      end else if (stall) begin
        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        pc_d        = npc_aligned;
        id_inst_d   = if_inst;
        id_pc_d     = pc_q;
        id_pc8_d    = if_pc8;
        id_valid_d  = 1'b1;
        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= {RESET_PC[31:2], 2'b00};
      id_inst_q   <= NOP_INST;
      id_pc_q     <= 32'h0;
      id_pc8_q    <= 32'h0;
      id_valid_q  <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_pc8_q    <= id_pc8_d;
      id_valid_q  <= id_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc        = pc_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_pc8    = id_pc8_q;
  assign id_valid  = id_valid_q;
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_pc_ifid.sv
// Bench for pipe_pc_ifid: directed scenarios and random traffic checked against a
// cycle-level behavioural model of the pc / IF-ID / step behaviour.
module tb_pipe_pc_ifid;

  localparam int CNT_W = 12;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      npc, if_inst, if_pc8;
  logic             stall, flush, step_mode, step;
  logic [31:0]      pc, id_inst, id_pc, id_pc8;
  logic             id_valid;
  logic [CNT_W-1:0] fetch_cnt, stall_cnt;
  logic [1:0]       step_state;

  int n_total = 0;
  int n_bad   = 0;

  // model state; m_st: 0 = RUN, 1 = HOLD, 2 = ADV
  logic [31:0] m_pc, m_inst, m_ipc, m_ipc8;
  logic        m_val, m_stepq;
  int          m_fc, m_sc, m_st;
  int          fc0;

  always #5 clk = ~clk;

  pipe_pc_ifid #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .if_inst    (if_inst),
    .if_pc8     (if_pc8),
    .stall      (stall),
    .flush      (flush),
    .step_mode  (step_mode),
    .step       (step),
    .pc         (pc),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_pc8     (id_pc8),
    .id_valid   (id_valid),
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt),
    .step_state (step_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_ipc8 = 32'h0;
    m_val = 1'b0; m_fc = 0; m_sc = 0; m_st = 1; m_stepq = 1'b1;
  endtask

  task automatic model_edge();
    bit en, rise;
    int nxt;
    if (rst) begin
      model_reset();
      return;
    end
    en   = (m_st == 0) || (m_st == 2);
    rise = step && !m_stepq;
    nxt  = m_st;
    if (m_st == 1)      nxt = !step_mode ? 0 : (rise ? 2 : 1);
    else if (m_st == 2) nxt = step_mode ? 1 : 0;
    else                nxt = step_mode ? 1 : 0;
    if (en) begin
      if (flush) begin
        m_pc = npc & 32'hFFFF_FFFC;
        m_inst = 32'h0; m_ipc = 32'h0; m_ipc8 = 32'h0; m_val = 1'b0;
      end else if (stall) begin
        if (m_sc < CMAX) m_sc = m_sc + 1;
      end else begin
        m_ipc  = m_pc;
        m_pc   = npc & 32'hFFFF_FFFC;
        m_inst = if_inst;
        m_ipc8 = if_pc8;
        m_val  = 1'b1;
        m_fc   = (m_fc + 1) % (CMAX + 1);
      end
    end
    m_stepq = step;
    m_st    = nxt;
  endtask

  task automatic check_all();
    check_eq("pc", pc, m_pc);
    check_eq("id_inst", id_inst, m_inst);
    check_eq("id_pc", id_pc, m_ipc);
    check_eq("id_pc8", id_pc8, m_ipc8);
    check_eq("id_valid", 32'(id_valid), 32'(m_val));
    check_eq("fetch_cnt", 32'(fetch_cnt), m_fc);
    check_eq("stall_cnt", 32'(stall_cnt), m_sc);
    check_eq("step_state", 32'(step_state), m_st);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic feed();
    npc    = m_pc + 32'd4;
    if_pc8 = m_pc + 32'd8;
  endtask

  initial begin
    #1_000_000;
    n_total++;
    n_bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    rst = 1'b1; npc = 32'h0; if_inst = 32'h0; if_pc8 = 32'h0;
    stall = 1'b0; flush = 1'b0; step_mode = 1'b0; step = 1'b0;
    #2;
    model_reset();
    check_all();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_state", 32'(step_state), 32'd1);
    tick();
    rst = 1'b0;

    // free run: one HOLD cycle out of reset, then one fetch per edge
    if_inst = 32'h2001_0005;
    feed(); tick();
    check_eq("run_state", 32'(step_state), 32'd0);
    check_eq("run_pc0", pc, 32'h0);
    feed(); tick();
    check_eq("run_pc4", pc, 32'h4);
    check_eq("run_inst", id_inst, 32'h2001_0005);
    check_eq("run_idpc", id_pc, 32'h0);
    check_eq("run_valid", 32'(id_valid), 32'd1);
    check_eq("run_fcnt", 32'(fetch_cnt), 32'd1);
    feed(); tick();
    check_eq("run_pc8", pc, 32'h8);

    stall = 1'b1;
    repeat (3) begin feed(); tick(); end
    check_eq("stall_pc", pc, 32'h8);
    check_eq("stall_cnt3", 32'(stall_cnt), 32'd3);
    check_eq("stall_fcnt", 32'(fetch_cnt), 32'd2);
    stall = 1'b0;
    feed(); tick();
    check_eq("release_pc", pc, 32'hC);

    flush = 1'b1; stall = 1'b1; npc = 32'h0000_0040;
    tick();
    check_eq("flush_pc", pc, 32'h40);
    check_eq("flush_inst", id_inst, 32'h0);
    check_eq("flush_valid", 32'(id_valid), 32'd0);
    check_eq("flush_scnt", 32'(stall_cnt), 32'd3);
    flush = 1'b0; stall = 1'b0;

    // single step: a long press advances exactly once
    step_mode = 1'b1;
    feed(); tick();
    check_eq("ss_hold", 32'(step_state), 32'd1);
    fc0 = m_fc;
    step = 1'b1;
    feed(); tick();
    check_eq("ss_adv", 32'(step_state), 32'd2);
    feed(); tick();
    check_eq("ss_back", 32'(step_state), 32'd1);
    repeat (8) begin feed(); tick(); end
    check_eq("ss_one", 32'(fetch_cnt), 32'((fc0 + 1) % (CMAX + 1)));
    step = 1'b0;
    feed(); tick();
    step = 1'b1;
    feed(); tick();
    feed(); tick();
    check_eq("ss_two", 32'(fetch_cnt), 32'((fc0 + 2) % (CMAX + 1)));
    step = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      stall     = ($urandom % 4) == 0;
      flush     = ($urandom % 8) == 0;
      step_mode = ($urandom % 6) == 0;
      step      = ($urandom % 3) == 0;
      npc       = $urandom;
      if_inst   = $urandom;
      if_pc8    = $urandom;
      tick();
    end

    // counter limits
    rst = 1'b1; tick(); rst = 1'b0;
    step_mode = 1'b0; step = 1'b0; flush = 1'b0; stall = 1'b1;
    tick();
    repeat (CMAX + 2) begin feed(); tick(); end
    check_eq("scnt_sat", 32'(stall_cnt), CMAX);
    stall = 1'b0;
    repeat (CMAX) begin feed(); tick(); end
    check_eq("fcnt_max", 32'(fetch_cnt), CMAX);
    feed(); tick();
    check_eq("fcnt_wrap", 32'(fetch_cnt), 32'd0);

    // async reset while in ADV, with the button still held
    step_mode = 1'b1;
    feed(); tick();
    step = 1'b0;
    feed(); tick();
    step = 1'b1;
    feed(); tick();
    check_eq("adv_before_rst", 32'(step_state), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check_eq("arst_pc", pc, 32'h0);
    check_eq("arst_state", 32'(step_state), 32'd1);
    check_eq("arst_fcnt", 32'(fetch_cnt), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) begin feed(); tick(); end
    check_eq("held_no_step", 32'(step_state), 32'd1);
    check_eq("held_fcnt", 32'(fetch_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
